// File: rtl/reg_bank_pkg.sv
// Shared definitions for the UART-facing register bank: address map, CTRL layout and reset values.
// The snapshot block is only built when REG_BANK_SNAPSHOT_EN is defined.
package reg_bank_pkg;

    localparam logic [7:0] CHIP_ID = 8'hA5;
    localparam logic [7:0] VERSION = 8'h01;

    localparam logic [7:0] ADDR_ID        = 8'h00;
    localparam logic [7:0] ADDR_VERSION   = 8'h01;
    localparam logic [7:0] ADDR_SCRATCH   = 8'h02;
    localparam logic [7:0] ADDR_CTRL      = 8'h03;
    localparam logic [7:0] ADDR_STATUS0   = 8'h04;
    localparam logic [7:0] ADDR_EVT_FLAGS = 8'h08;
    localparam logic [7:0] ADDR_EVT_MASK  = 8'h09;
    localparam logic [7:0] ADDR_GP_BASE   = 8'h10;
    localparam logic [7:0] ADDR_SNAP0     = 8'h20;

    // GP registers occupy one full 16-byte page, so the upper nibble selects the page.
    localparam logic [3:0] GP_PAGE = ADDR_GP_BASE[7:4];
    localparam int         NUM_GP  = 16;

    localparam int CTRL_ENABLE_BIT = 0;
    localparam int CTRL_MODE_LSB   = 1;
    localparam int CTRL_MODE_MSB   = 3;

    typedef struct packed {
        logic [CTRL_MODE_MSB-CTRL_MODE_LSB:0] mode;
        logic                                 enable;
    } ctrl_t;

    localparam logic [7:0] SCRATCH_RST  = 8'h00;
    localparam ctrl_t      CTRL_RST     = '{mode: 3'b000, enable: 1'b0};
    localparam logic [7:0] EVT_FLAGS_RST = 8'h00;
    localparam logic [7:0] EVT_MASK_RST  = 8'h00;
    localparam logic [7:0] GP_RST       = 8'h00;

endpackage

// File: rtl/reg_bank_snapshot.sv
// Free-running 32-bit counter with an atomic latch of its upper 24 bits.
// Only instantiated by reg_bank when REG_BANK_SNAPSHOT_EN is defined.
module reg_bank_snapshot (
    input  logic        clk,
    input  logic        reset,
    input  logic        latch,
    output logic [7:0]  count_lo,
    output logic [23:0] snap
);

    logic [31:0] count;

    // The upper bytes are frozen on the same edge the low byte is read, so a multi-byte read is coherent.
    always_ff @(posedge clk) begin
        if (reset) begin
            count <= 32'h0000_0000;
            snap  <= 24'h00_0000;
        end else begin
            count <= count + 32'd1;
            if (latch) begin
                snap <= count[31:8];
            end
        end
    end

    assign count_lo = count[7:0];

endmodule

// File: rtl/reg_bank.sv
// Host-visible register bank: RW control, RO status/ID, sticky events with irq, GP registers.
// Define REG_BANK_SNAPSHOT_EN to add the counter snapshot at 0x20..0x23.
module reg_bank
    import reg_bank_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    input  logic [7:0]   address,
    input  logic [7:0]   data_write_to_reg,
    input  logic         reg_en,
    input  logic         write_en,
    output logic [7:0]   data_read_from_reg,
    input  logic [31:0]  status_in,
    input  logic [7:0]   event_in,
    output logic         ctrl_enable,
    output logic [2:0]   ctrl_mode,
    output logic [127:0] gp_regs,
    output logic         irq
);

    logic       wr;
    logic       rd;
    logic       is_gp;
    logic [7:0] scratch;
    ctrl_t      ctrl;
    logic [7:0] evt_flags;
    logic [7:0] evt_mask;
    logic [7:0] gp_mem [NUM_GP];
    logic [7:0] clr_mask;
    logic [7:0] rd_mux;

    assign wr    = reg_en & write_en;
    assign rd    = reg_en & ~write_en;
    assign is_gp = (address[7:4] == GP_PAGE);

`ifdef REG_BANK_SNAPSHOT_EN
    logic [7:0]  count_lo;
    logic [23:0] snap;

    reg_bank_snapshot u_snapshot (
        .clk      (clk),
        .reset    (reset),
        .latch    (rd && (address == ADDR_SNAP0)),
        .count_lo (count_lo),
        .snap     (snap)
    );
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            scratch  <= SCRATCH_RST;
            ctrl     <= CTRL_RST;
            evt_mask <= EVT_MASK_RST;
            for (int k = 0; k < NUM_GP; k++) begin
                gp_mem[k] <= GP_RST;
            end
        end else if (wr) begin
            case (address)
                ADDR_SCRATCH:  scratch  <= data_write_to_reg;
                ADDR_CTRL:     ctrl     <= ctrl_t'(data_write_to_reg[CTRL_MODE_MSB:0]);
                ADDR_EVT_MASK: evt_mask <= data_write_to_reg;
                default: begin
                    if (is_gp) begin
                        gp_mem[address[3:0]] <= data_write_to_reg;
                    end
                end
            endcase
        end
    end

    // Clear is applied before OR-ing in new events, so a simultaneous event wins over a W1C.
    always_comb begin
        clr_mask = 8'h00;
        if (wr && (address == ADDR_EVT_FLAGS)) begin
            clr_mask = data_write_to_reg;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            evt_flags <= EVT_FLAGS_RST;
            irq       <= 1'b0;
        end else begin
            evt_flags <= (evt_flags & ~clr_mask) | event_in;
            irq       <= |(evt_flags & evt_mask);
        end
    end

    always_comb begin
        rd_mux = 8'h00;
        case (address)
            ADDR_ID:             rd_mux = CHIP_ID;
            ADDR_VERSION:        rd_mux = VERSION;
            ADDR_SCRATCH:        rd_mux = scratch;
            ADDR_CTRL:           rd_mux = {4'h0, ctrl};
            ADDR_STATUS0:        rd_mux = status_in[7:0];
            ADDR_STATUS0 + 8'd1: rd_mux = status_in[15:8];
            ADDR_STATUS0 + 8'd2: rd_mux = status_in[23:16];
            ADDR_STATUS0 + 8'd3: rd_mux = status_in[31:24];
            ADDR_EVT_FLAGS:      rd_mux = evt_flags;
            ADDR_EVT_MASK:       rd_mux = evt_mask;
`ifdef REG_BANK_SNAPSHOT_EN
            ADDR_SNAP0:          rd_mux = count_lo;
            ADDR_SNAP0 + 8'd1:   rd_mux = snap[7:0];
            ADDR_SNAP0 + 8'd2:   rd_mux = snap[15:8];
            ADDR_SNAP0 + 8'd3:   rd_mux = snap[23:16];
`endif
            default: begin
                if (is_gp) begin
                    rd_mux = gp_mem[address[3:0]];
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            data_read_from_reg <= 8'h00;
        end else if (rd) begin
            data_read_from_reg <= rd_mux;
        end
    end

    assign ctrl_enable = ctrl.enable;
    assign ctrl_mode   = ctrl.mode;

    for (genvar k = 0; k < NUM_GP; k++) begin : g_gp_out
        assign gp_regs[8*k +: 8] = gp_mem[k];
    end

endmodule

// File: tb/tb_reg_bank.sv
// Directed, table-driven bench for reg_bank; expectations follow REG_BANK_SNAPSHOT_EN when it is defined.
module tb_reg_bank;

    logic         clk = 1'b0;
    logic         reset;
    logic [7:0]   address;
    logic [7:0]   data_write_to_reg;
    logic         reg_en;
    logic         write_en;
    logic [7:0]   data_read_from_reg;
    logic [31:0]  status_in;
    logic [7:0]   event_in;
    logic         ctrl_enable;
    logic [2:0]   ctrl_mode;
    logic [127:0] gp_regs;
    logic         irq;

    int vec_count  = 0;
    int miscompares = 0;
    logic [31:0] cyc;

    typedef struct {
        logic       we;
        logic [7:0] addr;
        logic [7:0] wdata;
        logic       chk;
        logic [7:0] exp;
    } vec_t;

    vec_t vecs[$];

    reg_bank dut (
        .clk                (clk),
        .reset              (reset),
        .address            (address),
        .data_write_to_reg  (data_write_to_reg),
        .reg_en             (reg_en),
        .write_en           (write_en),
        .data_read_from_reg (data_read_from_reg),
        .status_in          (status_in),
        .event_in           (event_in),
        .ctrl_enable        (ctrl_enable),
        .ctrl_mode          (ctrl_mode),
        .gp_regs            (gp_regs),
        .irq                (irq)
    );

    always #5 clk = ~clk;

    // Reference cycle count: index of the next edge since the last reset release.
    always @(posedge clk) begin
        if (reset) cyc <= 32'd0;
        else       cyc <= cyc + 32'd1;
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check_output(input string name, input logic [127:0] act, input logic [127:0] exp);
        vec_count++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic apply_stimulus(input logic we, input logic [7:0] a, input logic [7:0] d);
        @(negedge clk);
        reg_en            = 1'b1;
        write_en          = we;
        address           = a;
        data_write_to_reg = d;
        @(negedge clk);
        reg_en   = 1'b0;
        write_en = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset  = 1'b1;
        reg_en = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
    endtask

    function automatic void add(input logic we, input logic [7:0] a, input logic [7:0] d,
                                input logic chk, input logic [7:0] exp);
        vec_t v;
        v.we = we; v.addr = a; v.wdata = d; v.chk = chk; v.exp = exp;
        vecs.push_back(v);
    endfunction

    initial begin
        logic [31:0] c;
        int guard;
        reset = 1'b1; reg_en = 1'b0; write_en = 1'b0; address = 8'h00;
        data_write_to_reg = 8'h00; event_in = 8'h00; status_in = 32'h1122_3344;

        // Reads of RO/RW registers, RO write protection, CTRL masking, unmapped space.
        add(0, 8'h00, 8'h00, 1, 8'hA5);
        add(0, 8'h01, 8'h00, 1, 8'h01);
        add(0, 8'h03, 8'h00, 1, 8'h00);
        add(0, 8'h08, 8'h00, 1, 8'h00);
        add(0, 8'h02, 8'h00, 1, 8'h00);
        add(0, 8'h09, 8'h00, 1, 8'h00);
        add(0, 8'h21, 8'h00, 1, 8'h00);
        add(1, 8'h03, 8'hFF, 0, 8'h00);
        add(0, 8'h03, 8'h00, 1, 8'h0F);
        add(1, 8'h00, 8'h12, 0, 8'h00);
        add(0, 8'h00, 8'h00, 1, 8'hA5);
        add(1, 8'h01, 8'h34, 0, 8'h00);
        add(0, 8'h01, 8'h00, 1, 8'h01);
        add(1, 8'h02, 8'hC3, 0, 8'h00);
        add(0, 8'h02, 8'h00, 1, 8'hC3);
        add(1, 8'h02, 8'h11, 1, 8'hC3);
        add(1, 8'h0A, 8'h77, 1, 8'hC3);
        add(0, 8'h0A, 8'h00, 1, 8'h00);
        add(0, 8'h30, 8'h00, 1, 8'h00);
        add(0, 8'hFF, 8'h00, 1, 8'h00);
        add(0, 8'h04, 8'h00, 1, 8'h44);
        add(0, 8'h05, 8'h00, 1, 8'h33);
        add(0, 8'h06, 8'h00, 1, 8'h22);
        add(0, 8'h07, 8'h00, 1, 8'h11);
        add(1, 8'h04, 8'h00, 0, 8'h00);
        add(0, 8'h04, 8'h00, 1, 8'h44);
        add(0, 8'h02, 8'h00, 1, 8'h11);
        add(1, 8'h03, 8'h0B, 0, 8'h00);
        add(0, 8'h03, 8'h00, 1, 8'h0B);

        do_reset();
        check_output("reset_rdata", data_read_from_reg, 8'h00);
        check_output("reset_irq", irq, 1'b0);
        check_output("reset_ctrl", {ctrl_enable, ctrl_mode}, 4'h0);
        check_output("reset_gp", gp_regs, 128'h0);

        for (int i = 0; i < vecs.size(); i++) begin
            apply_stimulus(vecs[i].we, vecs[i].addr, vecs[i].wdata);
            if (vecs[i].chk)
                check_output($sformatf("vec%0d_a%02h", i, vecs[i].addr), data_read_from_reg, vecs[i].exp);
        end
        check_output("ctrl_enable_0b", ctrl_enable, 1'b1);
        check_output("ctrl_mode_0b", ctrl_mode, 3'b101);
        apply_stimulus(1, 8'h03, 8'hFF);
        check_output("ctrl_enable_ff", ctrl_enable, 1'b1);
        check_output("ctrl_mode_ff", ctrl_mode, 3'b111);

        // Full-rate block write then block read of the GP page.
        @(negedge clk);
        for (int k = 0; k < 16; k++) begin
            reg_en = 1'b1; write_en = 1'b1;
            address = 8'h10 + 8'(k); data_write_to_reg = 8'(k);
            @(negedge clk);
        end
        for (int k = 0; k < 16; k++) begin
            reg_en = 1'b1; write_en = 1'b0; address = 8'h10 + 8'(k);
            @(negedge clk);
            check_output($sformatf("gp_rd%0d", k), data_read_from_reg, 8'(k));
        end
        reg_en = 1'b0;
        check_output("gp_regs", gp_regs, 128'h0F0E0D0C0B0A09080706050403020100);

        // Sticky events, mask, irq latency and set-beats-clear.
        event_in = 8'h05;
        @(negedge clk);
        event_in = 8'h00;
        apply_stimulus(1, 8'h09, 8'h04);
        check_output("irq_latency0", irq, 1'b0);
        @(negedge clk);
        check_output("irq_latency1", irq, 1'b1);
        apply_stimulus(0, 8'h08, 8'h00);
        check_output("flags_05", data_read_from_reg, 8'h05);
        @(negedge clk);
        reg_en = 1'b1; write_en = 1'b1; address = 8'h08; data_write_to_reg = 8'h04; event_in = 8'h04;
        @(negedge clk);
        reg_en = 1'b0; write_en = 1'b0; event_in = 8'h00;
        apply_stimulus(0, 8'h08, 8'h00);
        check_output("set_beats_clr", data_read_from_reg, 8'h05);
        check_output("irq_held", irq, 1'b1);
        apply_stimulus(1, 8'h08, 8'h01);
        apply_stimulus(0, 8'h08, 8'h00);
        check_output("partial_clr", data_read_from_reg, 8'h04);
        apply_stimulus(1, 8'h08, 8'h05);
        apply_stimulus(0, 8'h08, 8'h00);
        check_output("flags_clr", data_read_from_reg, 8'h00);
        check_output("irq_clr", irq, 1'b0);
        event_in = 8'h02;
        @(negedge clk);
        event_in = 8'h00;
        repeat (2) @(negedge clk);
        check_output("irq_masked", irq, 1'b0);

        // Reset lands after a read strobe but before the sample; a write under reset is dropped.
        apply_stimulus(1, 8'h02, 8'h5A);
        @(negedge clk);
        reg_en = 1'b1; write_en = 1'b0; address = 8'h02;
        @(posedge clk);
        #1;
        reset = 1'b1; reg_en = 1'b1; write_en = 1'b1; data_write_to_reg = 8'h77;
        @(negedge clk);
        check_output("rst_mid_pre", data_read_from_reg, 8'h5A);
        @(negedge clk);
        check_output("rst_mid_rdata", data_read_from_reg, 8'h00);
        reg_en = 1'b0; write_en = 1'b0;
        reset = 1'b0;
        apply_stimulus(0, 8'h02, 8'h00);
        check_output("rst_mid_scratch", data_read_from_reg, 8'h00);
        check_output("rst_mid_ctrl", {ctrl_enable, ctrl_mode}, 4'h0);

        // Snapshot: latch at count 255, then read upper bytes after the low byte has wrapped.
        do_reset();
        apply_stimulus(0, 8'h22, 8'h00);
        check_output("snap_rst", data_read_from_reg, 8'h00);
        guard = 0;
        while (cyc != 32'd255 && guard < 400) begin
            @(negedge clk);
            guard++;
        end
        check_output("snap_reach255", cyc, 32'd255);
        reg_en = 1'b1; write_en = 1'b0; address = 8'h20;
        @(negedge clk);
        reg_en = 1'b0;
`ifdef REG_BANK_SNAPSHOT_EN
        check_output("snap_lo255", data_read_from_reg, 8'hFF);
`else
        check_output("snap_lo255", data_read_from_reg, 8'h00);
`endif
        for (int k = 1; k < 4; k++) begin
            apply_stimulus(0, 8'h20 + 8'(k), 8'h00);
            check_output($sformatf("snap_b%0d", k), data_read_from_reg, 8'h00);
        end
        @(negedge clk);
        c = cyc;
        reg_en = 1'b1; write_en = 1'b0; address = 8'h20;
        @(negedge clk);
        reg_en = 1'b0;
`ifdef REG_BANK_SNAPSHOT_EN
        check_output("snap_lo2", data_read_from_reg, c[7:0]);
        apply_stimulus(0, 8'h21, 8'h00);
        check_output("snap_hi2", data_read_from_reg, c[15:8]);
`else
        check_output("snap_lo2", data_read_from_reg, 8'h00);
        apply_stimulus(0, 8'h21, 8'h00);
        check_output("snap_hi2", data_read_from_reg, 8'h00);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompares);
        $finish;
    end

endmodule

// File: doc/reg_bank.md
# reg_bank

Register bank sitting directly downstream of the UART register-access interface: it consumes the address/write-data/strobe bus and returns read data one cycle after a read strobe. It holds the design's RW control registers, read-only status and ID, a sticky event/interrupt block, and an atomic 32-bit free-running counter snapshot. It is the single register target for host access over UART.

## Interface
- `CHIP_ID`, 8'hA5, value returned at address 0x00
- `VERSION`, 8'h01, value returned at address 0x01
- `clk`  in  1  system clock
- `reset`  in  1  synchronous, active-high reset
- `address`  in  8  register address
- `data_write_to_reg`  in  8  write data
- `reg_en`  in  1  access strobe, one cycle per access
- `write_en`  in  1  qualifies `reg_en` as a write; ignored without `reg_en`
- `data_read_from_reg`  out  8  registered read data
- `status_in`  in  32  live status, bytes readable at 0x04..0x07
- `event_in`  in  8  single-cycle event pulses
- `ctrl_enable`  out  1  CTRL[0]
- `ctrl_mode`  out  3  CTRL[3:1]
- `gp_regs`  out  128  sixteen 8-bit general registers, byte k = bits [8k+7:8k]
- `irq`  out  1  OR of (EVT_FLAGS & EVT_MASK), registered

## Operation
- Map: 0x00 ID (RO); 0x01 VERSION (RO); 0x02 SCRATCH (RW); 0x03 CTRL (RW, bits [7:4] read 0, writes ignored); 0x04..0x07 STATUS bytes 0..3 (RO, little-endian); 0x08 EVT_FLAGS (W1C); 0x09 EVT_MASK (RW); 0x10..0x1F GP[0..15] (RW); 0x20..0x23 SNAPSHOT (RO); all other addresses read 0x00, writes ignored.
- Writes to RO addresses ignored, no side effects.
- Write: `reg_en & write_en` updates target register on that edge.
- Read: `reg_en & !write_en` registers selected value into `data_read_from_reg` on that edge; value holds until next read. Writes never change `data_read_from_reg`.
- EVT_FLAGS: bit i set when `event_in[i]`=1; cleared by write with bit i=1. Set and clear in same cycle: set wins.
- Snapshot: 32-bit counter increments every cycle, wraps 0xFFFFFFFF -> 0. Read of 0x20 returns counter[7:0] and latches counter[31:8] into SNAP on same edge; 0x21..0x23 return SNAP bytes 0..2. Reads of 0x21..0x23 without prior 0x20 return last latched (0 after reset).
- STATUS sampled combinationally at read edge; no synchroniser (caller supplies synchronous signals).

## Timing
- Read latency: data valid the cycle after the `reg_en` cycle; compatible with an interface that samples two cycles after strobe.
- Back-to-back strobes every cycle supported (block read/write at full rate).
- `irq` updates one cycle after the flag/mask change.
- Reset values: `data_read_from_reg`=0, SCRATCH=0, CTRL=0 (`ctrl_enable`=0, `ctrl_mode`=0), EVT_FLAGS=0, EVT_MASK=0, GP all 0, counter=0, SNAP=0, `irq`=0.
- Reset mid-access: reset wins; pending write discarded, read data cleared.
- Counter reflects its value at the read edge: after reset release, a read of 0x20 at cycle n (n counted from first non-reset cycle, starting at 0) returns n[7:0].

## Configuration
- `REG_BANK_SNAPSHOT_EN` defined: counter, SNAP and 0x20..0x23 as above.
- Undefined: counter and SNAP not built; 0x20..0x23 read 0x00 like unmapped addresses.

## Structure
- Package `reg_bank_pkg`: address localparams (ADDR_ID, ADDR_VERSION, ADDR_SCRATCH, ADDR_CTRL, ADDR_STATUS0, ADDR_EVT_FLAGS, ADDR_EVT_MASK, ADDR_GP_BASE, ADDR_SNAP0), CTRL bit-field positions, reset values.
- Sub-module `reg_bank_snapshot`: counter + SNAP latch, inputs `latch`, outputs `count_lo[7:0]`, `snap[23:0]`; instantiated only under `REG_BANK_SNAPSHOT_EN`.

## Test plan
- Reset, read 0x00, 0x01, 0x03, 0x08 -> 0xA5, 0x01, 0x00, 0x00; `irq`=0.
- Write 0x03=0xFF, read 0x03 -> 0x0F; `ctrl_enable`=1, `ctrl_mode`=3'b111; write 0x00=0x12, read 0x00 -> 0xA5.
- Back-to-back writes 0x10..0x1F = 0x00..0x0F, then back-to-back reads -> each datum one cycle after its strobe; `gp_regs`=0x0F0E..0100.
- Pulse `event_in`=0x05, mask 0x09=0x04 -> flags 0x05, `irq`=1 next cycle; write 0x08=0x04 same cycle as `event_in`=0x04 -> flag bit 2 stays 1; write 0x08=0x05 alone -> flags 0, `irq`=0.
- Snapshot: hold counter across 0x00FFFFFF->0x01000000; read 0x20 at 0x00FFFFFF -> 0xFF, then 0x21..0x23 -> 0xFF,0xFF,0x00 despite rollover; without macro -> all 0x00.
- Assert `reset` between strobe and sample of a read of 0x02=0x5A -> `data_read_from_reg`=0, SCRATCH=0.
